usb_bit_receiver: RTL and testbench
===================================

// Module: usb_bit_receiver
// PURPOSE
//  Receive-side bit front end for the USB host. Consumes the DP/DM bus driven
//  by the device, sits downstream of the wires that PH_Sender drives, and feeds
//  the PH receiver.
//  Finds SYNC, NRZI-decodes, strips stuffed bits, detects EOP and delivers
//  LSB-first bytes with packet framing and error flags.
//  Rate is one bus bit per clock, the same as the transmit path.
// PARAMETERS
//  MAX_BYTES  11  max bytes per packet (PID + 8 data + 2 CRC); more = error
// PORTS
//  clock          in   1  single clock
//  reset_n        in   1  asynchronous, active-low reset
//  DP_in          in   1  bus D+ (sampled each clock)
//  DM_in          in   1  bus D- (sampled each clock)
//  rx_enable      in   1  1 = hunt for packets; 0 = forced to IDLE
//  rx_byte        out  8  assembled byte; held until the next byte
//  rx_byte_valid  out  1  1-cycle pulse per byte
//  rx_sop         out  1  1-cycle pulse when SYNC completes
//  rx_eop         out  1  1-cycle pulse on a clean EOP
//  rx_error       out  1  1-cycle pulse on any packet error
//  rx_busy        out  1  high from SYNC start to EOP/error recovery
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, prev_level=J.
//  Bus states: J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11. DP/DM are registered
//  once on entry, so the FSM sees them 1 cycle late.
//  NRZI decode: same level as the previous bit = 1; a J<->K transition = 0.
//  FSM states:
//   IDLE: bus J. First K -> SYNC.
//   SYNC: expects K J K J K J K K (decoded 0000_0001).
//    Final K -> DATA; rx_sop pulses the next cycle.
//    Any mismatch -> IDLE silently, with no rx_error.
//   DATA:
//    - Ones counter: counts consecutive decoded 1s.
//    - After 6 consecutive 1s the next bit is a stuff bit: it must be 0, it is
//      dropped, and the counter clears.
//    - If that stuff bit is 1 -> stuff error.
//    - Kept bits shift in LSB-first. The 8th kept bit loads rx_byte, and
//      rx_byte_valid pulses 2 clocks after that bit is on DP/DM.
//    - SE0 -> EOP1.
//    - SE1 -> error.
//    - Byte count > MAX_BYTES -> error.
//   EOP1: needs SE0 -> EOP2. Any other bus state -> error.
//   EOP2:
//    - J -> IDLE, with rx_eop pulsing iff the bit count is a multiple of 8
//      and at least 1 byte was received; otherwise rx_error pulses.
//    - SE0 held more than 2 cycles: stay in EOP2.
//    - K or SE1 -> error.
//   ERRWAIT: entered on any error; rx_error pulses once. Waits for 2 consecutive
//    J cycles, then goes to IDLE. No bytes are emitted in this state.
//  Simultaneous events:
//   - A stuff error on the cycle that completes a byte: the error wins and the
//     byte is not emitted.
//   - rx_eop and rx_error are never high in the same cycle.
//   - rx_byte_valid never coincides with rx_sop.
//  rx_enable deasserted mid-packet -> IDLE next cycle, with no eop/error pulse.
//  Async reset mid-packet -> immediate reset values; no partial byte is emitted.
// CONFIGURATION
//  USB_RX_PID_CHECK_EN
//   Defined: the first byte must satisfy byte[7:4] == ~byte[3:0]. On a mismatch
//    the PID byte is still emitted and rx_error pulses on the next cycle; the FSM
//    then goes to ERRWAIT.
//   Undefined: there is no PID check, and the first byte is treated like any other.
// STRUCTURE
//  USBPkg:
//   - bus_state_t
//   - rx_state_t enum (IDLE, SYNC, DATA, EOP1, EOP2, ERRWAIT)
//   - SYNC_PATTERN constant 8'b1000_0000, the bus order as decoded
//   - STUFF_LIMIT = 6
//  Sub-module usb_nrzi_unstuffer holds the NRZI decode, the ones counter and
//  the stuff-bit drop/error detection. It outputs bit, bit_valid and stuff_err.
//  The top level holds the FSM, byte assembly and EOP logic.
// TESTING
//  1. SYNC + ACK PID 0xD2 + SE0,SE0,J -> rx_sop; one byte 0xD2; rx_eop; rx_error stays 0.
//  2. DATA0 carrying 0f21000000000000, looped back from PH_Sender -> 11 bytes:
//     C3,0F,21, six 00s, then the 2 CRC bytes as driven; rx_eop.
//  3. Payload FFFF000000000000 -> stuffed 0s are removed and the bytes read
//     FF,FF,00...; no error.
//  4. Seven consecutive decoded 1s in DATA -> rx_error pulses once, no further
//     bytes, and the FSM returns to IDLE after 2 J cycles.
//  5. SE1 mid-byte, EOP after 12 bits, or a 12th byte -> rx_error each time,
//     with no rx_eop.
//  6. reset_n low for 1 cycle mid-payload -> all outputs 0 at once; the next
//     packet is received correctly. With USB_RX_PID_CHECK_EN defined, PID 0xC4
//     -> byte C4 emitted, then rx_error.

Source files
------------

// File: rtl/usb_bit_receiver_pkg.sv
// Shared types and constants for the USB receive bit front end.
package usb_bit_receiver_pkg;

  typedef enum logic [1:0] {
    BUS_SE0 = 2'b00,
    BUS_K   = 2'b01,
    BUS_J   = 2'b10,
    BUS_SE1 = 2'b11
  } bus_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_SYNC,
    RX_DATA,
    RX_EOP1,
    RX_EOP2,
    RX_ERRWAIT
  } rx_state_t;

  // Bit i is the i-th decoded SYNC bit in bus order (KJKJKJKK -> 0,0,0,0,0,0,0,1).
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam int         STUFF_LIMIT  = 6;

  function automatic logic is_data_level(input bus_state_t s);
    return (s == BUS_J) || (s == BUS_K);
  endfunction

endpackage

// File: rtl/usb_nrzi_unstuffer.sv
// NRZI decoder with consecutive-ones tracking, stuff-bit removal and stuff error detection.
module usb_nrzi_unstuffer
  import usb_bit_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  bus_state_t bus,
  input  logic       active,
  output logic       data_bit,
  output logic       bit_valid,
  output logic       stuff_err
);

  bus_state_t prev_level;
  logic [2:0] ones_cnt;
  logic       level_ok;
  logic       stuff_slot;

  assign level_ok   = is_data_level(bus);
  assign data_bit   = (bus == prev_level);
  assign stuff_slot = (ones_cnt == 3'(STUFF_LIMIT));
  assign bit_valid  = active && level_ok && !stuff_slot;
  assign stuff_err  = active && level_ok && stuff_slot && data_bit;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_level <= BUS_J;
      ones_cnt   <= '0;
    end else begin
      if (level_ok) prev_level <= bus;
      if (!active) begin
        ones_cnt <= '0;
      end else if (level_ok) begin
        if (stuff_slot || !data_bit) ones_cnt <= '0;
        else                         ones_cnt <= ones_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_bit_receiver.sv
// USB receive front end: SYNC hunt, byte assembly, EOP framing and error reporting.
// Optional PID check enabled by defining USB_RX_PID_CHECK_EN.
module usb_bit_receiver
  import usb_bit_receiver_pkg::*;
#(
  parameter int MAX_BYTES = 11
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       DP_in,
  input  logic       DM_in,
  input  logic       rx_enable,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_error,
  output logic       rx_busy
);

  localparam int BCW = $clog2(MAX_BYTES + 1);

  rx_state_t      state, next_state;
  bus_state_t     bus_q;
  logic           data_bit, bit_valid, stuff_err, in_data;
  logic [6:0]     shreg;
  logic [7:0]     assembled;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [2:0]     sync_idx;
  logic           j_seen;
  logic           pid_bad, pid_err_q;
  logic           take_bit, emit_byte, emit_sop, emit_eop, emit_err;

  assign in_data   = (state == RX_DATA);
  assign assembled = {data_bit, shreg};

`ifdef USB_RX_PID_CHECK_EN
  assign pid_bad = (byte_cnt == '0) && (assembled[7:4] != ~assembled[3:0]);
`else
  assign pid_bad = 1'b0;
`endif

  usb_nrzi_unstuffer u_unstuffer (
    .clk       (clock),
    .rst_n     (reset_n),
    .bus       (bus_q),
    .active    (in_data),
    .data_bit  (data_bit),
    .bit_valid (bit_valid),
    .stuff_err (stuff_err)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_q <= BUS_J;
      state <= RX_IDLE;
    end else begin
      bus_q <= bus_state_t'({DP_in, DM_in});
      state <= next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    take_bit   = 1'b0;
    emit_byte  = 1'b0;
    emit_sop   = 1'b0;
    emit_eop   = 1'b0;
    emit_err   = 1'b0;
    unique case (state)
      RX_IDLE: if (bus_q == BUS_K) next_state = RX_SYNC;
      RX_SYNC: begin
        if (is_data_level(bus_q) && (data_bit == SYNC_PATTERN[sync_idx])) begin
          if (sync_idx == 3'd7) begin
            next_state = RX_DATA;
            emit_sop   = 1'b1;
          end
        end else begin
          next_state = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (pid_err_q || bus_q == BUS_SE1 || stuff_err) begin
          next_state = RX_ERRWAIT;
        end else if (bus_q == BUS_SE0) begin
          next_state = RX_EOP1;
        end else if (bit_valid) begin
          if (bit_cnt == 3'd7 && byte_cnt == BCW'(MAX_BYTES)) begin
            next_state = RX_ERRWAIT;
          end else begin
            take_bit  = 1'b1;
            emit_byte = (bit_cnt == 3'd7);
          end
        end
      end
      RX_EOP1: next_state = (bus_q == BUS_SE0) ? RX_EOP2 : RX_ERRWAIT;
      RX_EOP2: begin
        if (bus_q == BUS_J) begin
          if (bit_cnt == 3'd0 && byte_cnt != '0) begin
            next_state = RX_IDLE;
            emit_eop   = 1'b1;
          end else begin
            next_state = RX_ERRWAIT;
          end
        end else if (bus_q != BUS_SE0) begin
          next_state = RX_ERRWAIT;
        end
      end
      RX_ERRWAIT: if (bus_q == BUS_J && j_seen) next_state = RX_IDLE;
      default: next_state = RX_IDLE;
    endcase
    // Disabling the receiver abandons the packet without any framing pulse.
    if (!rx_enable) begin
      next_state = RX_IDLE;
      take_bit   = 1'b0;
      emit_byte  = 1'b0;
      emit_sop   = 1'b0;
      emit_eop   = 1'b0;
    end
    emit_err = (next_state == RX_ERRWAIT) && (state != RX_ERRWAIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      rx_sop        <= 1'b0;
      rx_eop        <= 1'b0;
      rx_error      <= 1'b0;
      rx_busy       <= 1'b0;
      pid_err_q     <= 1'b0;
      shreg         <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      sync_idx      <= 3'd1;
      j_seen        <= 1'b0;
    end else begin
      rx_byte_valid <= emit_byte;
      rx_sop        <= emit_sop;
      rx_eop        <= emit_eop;
      rx_error      <= emit_err;
      rx_busy       <= (next_state != RX_IDLE);
      pid_err_q     <= emit_byte && pid_bad;
      if (emit_byte) rx_byte <= assembled;
      if (state == RX_IDLE || state == RX_SYNC) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (take_bit) begin
        shreg   <= assembled[7:1];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 1'b1;
      end
      sync_idx <= (state == RX_SYNC) ? sync_idx + 3'd1 : 3'd1;
      j_seen   <= (state == RX_ERRWAIT) && (bus_q == BUS_J);
    end
  end

endmodule

// File: tb/tb_usb_bit_receiver.sv
// Scoreboard bench for usb_bit_receiver: directed packets encoded by a bench-side NRZI/stuffer.
module tb_usb_bit_receiver;

  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;

  typedef enum int {EV_NONE, EV_SOP, EV_BYTE, EV_EOP, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;
  typedef logic [7:0] byte_q_t[$];

  logic       clock = 1'b0;
  logic       reset_n, DP_in, DM_in, rx_enable;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, rx_sop, rx_eop, rx_error, rx_busy;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [1:0] cur = J;
  int         ones = 0;

  usb_bit_receiver dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .DP_in         (DP_in),
    .DM_in         (DM_in),
    .rx_enable     (rx_enable),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_sop        (rx_sop),
    .rx_eop        (rx_eop),
    .rx_error      (rx_error),
    .rx_busy       (rx_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", k, EV_NONE);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (k == EV_BYTE && e.kind == EV_BYTE) check("byte_value", d, e.data);
    end
  endtask

  // Monitor: outputs are registered on posedge, sampled on negedge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (rx_sop)        observe(EV_SOP, 8'h00);
      if (rx_byte_valid) observe(EV_BYTE, rx_byte);
      if (rx_eop)        observe(EV_EOP, 8'h00);
      if (rx_error)      observe(EV_ERR, 8'h00);
    end
  end

  function automatic logic [15:0] crc16(input byte_q_t d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  task automatic send_sym(input logic [1:0] s);
    @(negedge clock);
    {DP_in, DM_in} = s;
  endtask

  task automatic send_bit(input logic b);
    if (!b) cur = (cur == J) ? K : J;
    send_sym(cur);
  endtask

  task automatic send_sync();
    cur  = J;
    ones = 0;
    for (int i = 0; i < 8; i++) send_bit(i == 7);
    push(EV_SOP, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_it);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      ones = b[i] ? ones + 1 : 0;
      if (ones == 6) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
    if (expect_it) push(EV_BYTE, b);
  endtask

  task automatic send_raw(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[i]);
  endtask

  task automatic send_eop();
    send_sym(SE0);
    send_sym(SE0);
    send_sym(J);
    cur = J;
  endtask

  task automatic idle(input int n);
    cur = J;
    repeat (n) send_sym(J);
  endtask

  task automatic drain(input string name);
    idle(6);
    check(name, exp_q.size(), 0);
  endtask

  task automatic send_packet(input byte_q_t pkt);
    send_sync();
    foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    send_eop();
    push(EV_EOP, 8'h00);
    idle(4);
  endtask

  task automatic build_data_pkt(input logic [7:0] pid, input byte_q_t data, output byte_q_t pkt);
    logic [15:0] crc;
    crc = crc16(data);
    pkt = {};
    pkt.push_back(pid);
    foreach (data[i]) pkt.push_back(data[i]);
    pkt.push_back(crc[7:0]);
    pkt.push_back(crc[15:8]);
  endtask

  initial begin
    byte_q_t data, pkt;
    reset_n   = 1'b0;
    {DP_in, DM_in} = J;
    rx_enable = 1'b1;
    #1;
    check("reset_outputs", {rx_byte, rx_byte_valid, rx_sop, rx_eop, rx_error, rx_busy}, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    idle(3);

    // ACK handshake
    pkt = '{8'hD2};
    send_packet(pkt);
    drain("ack_drain");

    // DATA0 0f21000000000000 with CRC16
    data = '{8'h0F, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    build_data_pkt(8'hC3, data, pkt);
    check("data0_len", pkt.size(), 11);
    send_packet(pkt);
    drain("data0_drain");

    // Heavy bit stuffing
    data = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    build_data_pkt(8'hC3, data, pkt);
    send_packet(pkt);
    drain("stuff_drain");

    // Seven decoded ones -> stuff error, then recovery after two J cycles
    send_sync();
    push(EV_ERR, 8'h00);
    send_raw(8'h7F, 7);
    send_raw(8'hFF, 8);
    check("errwait_busy_on_k", rx_busy, 1);
    send_sym(J);
    send_sym(J);
    @(negedge clock);
    check("errwait_busy_before_idle", rx_busy, 1);
    @(negedge clock);
    check("errwait_idle_after_2j", rx_busy, 0);
    drain("stuff_err_drain");

    // SE1 in the middle of a byte
    send_sync();
    send_byte(8'hD2, 1'b1);
    send_raw(8'h05, 3);
    push(EV_ERR, 8'h00);
    send_sym(SE1);
    idle(4);
    drain("se1_drain");

    // EOP after 12 kept bits
    send_sync();
    send_byte(8'hD2, 1'b1);
    send_raw(8'h05, 4);
    push(EV_ERR, 8'h00);
    send_eop();
    idle(4);
    drain("eop12_drain");

    // 12th byte overflows the packet
    send_sync();
    send_byte(8'hD2, 1'b1);
    for (int i = 1; i <= 10; i++) send_byte(8'(i * 17), 1'b1);
    push(EV_ERR, 8'h00);
    send_byte(8'hA5, 1'b0);
    send_eop();
    idle(4);
    drain("overflow_drain");

    // rx_enable dropped mid-packet
    send_sync();
    send_byte(8'hD2, 1'b1);
    send_raw(8'h03, 3);
    @(negedge clock);
    rx_enable = 1'b0;
    {DP_in, DM_in} = J;
    cur = J;
    repeat (2) @(negedge clock);
    check("disable_busy", rx_busy, 0);
    rx_enable = 1'b1;
    drain("disable_drain");

    // Async reset mid-payload, then a clean packet
    send_sync();
    send_byte(8'hC3, 1'b1);
    send_raw(8'h05, 5);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", {rx_byte, rx_byte_valid, rx_sop, rx_eop, rx_error, rx_busy}, 0);
    @(negedge clock);
    {DP_in, DM_in} = J;
    cur = J;
    reset_n = 1'b1;
    idle(3);
    pkt = '{8'hD2};
    send_packet(pkt);
    drain("post_reset_drain");

`ifdef USB_RX_PID_CHECK_EN
    // Bad PID: byte still delivered, error on the following cycle
    send_sync();
    send_byte(8'hC4, 1'b1);
    push(EV_ERR, 8'h00);
    send_eop();
    idle(4);
    drain("pid_check_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
